// File: rtl/hdmi_packet_pkg.sv
// Shared types, sizes and the BCH parity step for the HDMI data-island packet assembler.
// The ECC step shifts LSB-first and feeds back G(x)=1+x^6+x^7+x^8.
package hdmi_packet_pkg;

    typedef logic [55:0] packet_sub_t;
    typedef logic [23:0] packet_header_t;

    localparam int HEADER_BITS = 24;
    localparam int SUB_PAIRS   = 28;
    localparam int PACKET_LEN  = 32;

    localparam logic [7:0] ECC_POLY_DEFAULT = 8'h83;

    function automatic logic [7:0] ecc_step(
        input logic [7:0] e,
        input logic       d,
        input logic [7:0] poly = ECC_POLY_DEFAULT
    );
        logic f;
        f = e[0] ^ d;
        return (e >> 1) ^ (f ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_packet_ecc.sv
// BCH parity accumulator: BITS_PER_CLK chained steps per enabled clock, bit 0 first.
// seed_zero restarts the chain from zero so packets need no clear cycle.
module hdmi_packet_ecc
    import hdmi_packet_pkg::*;
#(
    parameter int         BITS_PER_CLK = 1,
    parameter logic [7:0] POLY         = ECC_POLY_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seed_zero,
    input  logic                    enable,
    input  logic [BITS_PER_CLK-1:0] data,
    output logic [7:0]              ecc
);

    logic [7:0] next;

    always_comb begin
        next = seed_zero ? 8'h00 : ecc;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            next = ecc_step(next, data[i], POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ecc <= 8'h00;
        end else if (enable) begin
            ecc <= next;
        end
    end

endmodule

// File: rtl/hdmi_packet_assembler.sv
// Serialises one header and four subpackets into a 32-cycle data-island packet with BCH parity.
// Define HDMI_PACKET_SNAPSHOT_EN to capture the sources at index 0 instead of reading them live.
module hdmi_packet_assembler
    import hdmi_packet_pkg::*;
#(
    parameter logic [7:0] ECC_POLY = ECC_POLY_DEFAULT
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              data_island_period,
    input  packet_header_t    header,
    input  packet_sub_t [3:0] sub,
    output logic [8:0]        packet_data,
    output logic [4:0]        packet_counter,
    output logic              packet_last
);

    logic [4:0]        c;
    logic              first;
    logic              hdr_run;
    logic              sub_run;
    packet_header_t    hdr;
    packet_sub_t [3:0] sb;
    logic [7:0]        ecc_hdr;
    logic [7:0]        ecc_sub [4];
    logic              ch0;
    logic [3:0]        ch1;
    logic [3:0]        ch2;

    assign first   = (c == 5'd0);
    assign hdr_run = data_island_period && (c < 5'(HEADER_BITS));
    assign sub_run = data_island_period && (c < 5'(SUB_PAIRS));

`ifdef HDMI_PACKET_SNAPSHOT_EN
    packet_header_t    hdr_snap;
    packet_sub_t [3:0] sub_snap;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hdr_snap <= '0;
            sub_snap <= '0;
        end else if (data_island_period && first) begin
            hdr_snap <= header;
            sub_snap <= sub;
        end
    end

    // Index 0 has no snapshot yet, so it reads the live sources.
    assign hdr = first ? header : hdr_snap;
    assign sb  = first ? sub : sub_snap;
`else
    assign hdr = header;
    assign sb  = sub;
`endif

    hdmi_packet_ecc #(
        .BITS_PER_CLK (1),
        .POLY         (ECC_POLY)
    ) u_ecc_hdr (
        .clk       (clk_pixel),
        .reset     (reset),
        .seed_zero (first),
        .enable    (hdr_run),
        .data      (hdr[c]),
        .ecc       (ecc_hdr)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub
        hdmi_packet_ecc #(
            .BITS_PER_CLK (2),
            .POLY         (ECC_POLY)
        ) u_ecc_sub (
            .clk       (clk_pixel),
            .reset     (reset),
            .seed_zero (first),
            .enable    (sub_run),
            .data      ({sb[k][{c, 1'b1}], sb[k][{c, 1'b0}]}),
            .ecc       (ecc_sub[k])
        );
    end

    always_comb begin
        ch0 = (c < 5'(HEADER_BITS)) ? hdr[c] : ecc_hdr[c[2:0]];
        ch1 = '0;
        ch2 = '0;
        for (int k = 0; k < 4; k++) begin
            if (c < 5'(SUB_PAIRS)) begin
                ch1[k] = sb[k][{c, 1'b0}];
                ch2[k] = sb[k][{c, 1'b1}];
            end else begin
                ch1[k] = ecc_sub[k][{c[1:0], 1'b0}];
                ch2[k] = ecc_sub[k][{c[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            c              <= 5'd0;
            packet_data    <= 9'd0;
            packet_counter <= 5'd0;
            packet_last    <= 1'b0;
        end else if (!data_island_period) begin
            c              <= 5'd0;
            packet_data    <= 9'd0;
            packet_counter <= 5'd0;
            packet_last    <= 1'b0;
        end else begin
            c              <= c + 5'd1;
            packet_data    <= {ch2, ch1, ch0};
            packet_counter <= c;
            packet_last    <= (c == 5'(PACKET_LEN - 1));
        end
    end

endmodule
